// File: rtl/alfa_exmu_pkg.sv
// Shared constants and types for the ExMU memory-side line mover.
//
// Contents:
//   LINE_WIDTH / POINT_WIDTH / POINTS_PER_LINE  geometry of one cache line
//   LINE_BYTES / LINE_SHIFT                     byte footprint of a line in memory
//   ID_WIDTH, ID_LINE_MSB / ID_LINE_LSB         where the line index sits inside a point ID
//   mover_state_e                               line mover FSM states
//   line_index()                                extract the line index from a point ID
package alfa_exmu_pkg;

  localparam int LINE_WIDTH      = 2048;
  localparam int POINT_WIDTH     = 64;
  localparam int POINTS_PER_LINE = 32;
  localparam int LINE_BYTES      = 256;
  localparam int LINE_SHIFT      = 8;
  localparam int ID_WIDTH        = 19;
  localparam int ID_LINE_MSB     = 18;
  localparam int ID_LINE_LSB     = 5;
  localparam int LINE_IDX_W      = ID_LINE_MSB - ID_LINE_LSB + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    DONE_RD = 3'd3,
    WR_BEAT = 3'd4,
    DONE_WR = 3'd5
  } mover_state_e;

  function automatic logic [LINE_IDX_W-1:0] line_index(input logic [ID_WIDTH-1:0] id);
    return id[ID_LINE_MSB:ID_LINE_LSB];
  endfunction

endpackage

// File: rtl/exmu_beat_serializer.sv
// Selects one BEAT_WIDTH slice out of a latched cache line.
//
// Ports:
//   line       in   LINE_WIDTH  line being written back (held stable by the mover)
//   beat       in   CNT_W       index of the beat currently offered to memory
//   beat_data  out  BEAT_WIDTH  line[beat*BEAT_WIDTH +: BEAT_WIDTH]
module exmu_beat_serializer
  import alfa_exmu_pkg::*;
#(
  parameter int BEAT_WIDTH = 256,
  parameter int NBEATS     = LINE_WIDTH / BEAT_WIDTH,
  parameter int CNT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic [LINE_WIDTH-1:0] line,
  input  logic [CNT_W-1:0]      beat,
  output logic [BEAT_WIDTH-1:0] beat_data
);

  always_comb begin
    beat_data = '0;
    for (int k = 0; k < NBEATS; k++) begin
      if (beat == CNT_W'(k)) beat_data = line[k*BEAT_WIDTH +: BEAT_WIDTH];
    end
  end

endmodule

// File: rtl/exmu_line_mover.sv
// Moves whole 2048-bit cache lines between ExMU and a BEAT_WIDTH memory port.
// Reads fetch a line as one burst request followed by NBEATS data beats;
// writes push the latched ExMU payload out beat by beat with per-beat addresses.
//
// Ports:
//   i_SYSTEM_clk / i_SYSTEM_rst            clock, synchronous active-high reset
//   i_CU_lineRead, i_CU_lineReadID         read request pulse and point ID
//   o_INT_readPayload, o_INT_readDone      assembled line and its 1-cycle valid pulse
//   i_CU_lineWrite, i_ExMU_writeID,
//   i_ExMU_writePayload                    write request pulse, point ID, line data
//   o_INT_writeDone                        1-cycle pulse after the last write beat
//   o_INT_busy                             high whenever not IDLE
//   o_status                               [0] dropped-request sticky, [1] read active, [2] write active
//   o_MEM_rdReq/rdAddr, i_MEM_rdReqReady   read burst request channel
//   i_MEM_rdValid/rdData                   read beat channel (no backpressure)
//   o_MEM_wrValid/wrAddr/wrData,
//   i_MEM_wrReady                          write beat channel
module exmu_line_mover
  import alfa_exmu_pkg::*;
#(
  parameter int                    BEAT_WIDTH = 256,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    i_SYSTEM_clk,
  input  logic                    i_SYSTEM_rst,
  input  logic                    i_CU_lineRead,
  input  logic [ID_WIDTH-1:0]     i_CU_lineReadID,
  output logic [LINE_WIDTH-1:0]   o_INT_readPayload,
  output logic                    o_INT_readDone,
  input  logic                    i_CU_lineWrite,
  input  logic [ID_WIDTH-1:0]     i_ExMU_writeID,
  input  logic [LINE_WIDTH-1:0]   i_ExMU_writePayload,
  output logic                    o_INT_writeDone,
  output logic                    o_INT_busy,
  output logic [31:0]             o_status,
  output logic                    o_MEM_rdReq,
  output logic [ADDR_WIDTH-1:0]   o_MEM_rdAddr,
  input  logic                    i_MEM_rdReqReady,
  input  logic                    i_MEM_rdValid,
  input  logic [BEAT_WIDTH-1:0]   i_MEM_rdData,
  output logic                    o_MEM_wrValid,
  output logic [ADDR_WIDTH-1:0]   o_MEM_wrAddr,
  output logic [BEAT_WIDTH-1:0]   o_MEM_wrData,
  input  logic                    i_MEM_wrReady
);

  localparam int NBEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(BEAT_WIDTH / 8);
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(NBEATS - 1);

  mover_state_e            state_q, state_d;
  logic [CNT_W-1:0]        beat_q;
  logic [LINE_WIDTH-1:0]   payload_q;
  logic [LINE_WIDTH-1:0]   wr_line_q;
  logic [ADDR_WIDTH-1:0]   line_addr_q;
  logic                    drop_q;

  logic rd_take, wr_take, drop_req;
  logic beat_last, rd_active, wr_active;
  logic [BEAT_WIDTH-1:0]   ser_data;

  // Point IDs only carry the line index in their upper bits; the point offset is don't-care.
  logic unused_id_bits;
  assign unused_id_bits = ^{i_CU_lineReadID[ID_LINE_LSB-1:0], i_ExMU_writeID[ID_LINE_LSB-1:0]};

  function automatic logic [ADDR_WIDTH-1:0] line_byte_addr(input logic [LINE_IDX_W-1:0] idx);
    return BASE_ADDR + (ADDR_WIDTH'(idx) << LINE_SHIFT);
  endfunction

  assign beat_last = (beat_q == LAST_BEAT);

  // Next-state logic. A write always wins a same-cycle collision so the
  // writeback lands before any refetch of the same line; the loser is
  // recorded in the sticky drop flag and the CU is expected to reissue it.
  always_comb begin
    state_d  = state_q;
    rd_take  = 1'b0;
    wr_take  = 1'b0;
    drop_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_CU_lineWrite) begin
          wr_take  = 1'b1;
          drop_req = i_CU_lineRead;
          state_d  = WR_BEAT;
        end else if (i_CU_lineRead) begin
          rd_take = 1'b1;
          state_d = RD_REQ;
        end
      end
      RD_REQ:  if (i_MEM_rdReqReady) state_d = RD_DATA;
      RD_DATA: if (i_MEM_rdValid && beat_last) state_d = DONE_RD;
      DONE_RD: state_d = IDLE;
      WR_BEAT: if (i_MEM_wrReady && beat_last) state_d = DONE_WR;
      DONE_WR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) drop_req = i_CU_lineRead | i_CU_lineWrite;
  end

  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      payload_q   <= '0;
      wr_line_q   <= '0;
      line_addr_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (drop_req) drop_q <= 1'b1;
      if (rd_take) line_addr_q <= line_byte_addr(line_index(i_CU_lineReadID));
      if (wr_take) begin
        line_addr_q <= line_byte_addr(line_index(i_ExMU_writeID));
        wr_line_q   <= i_ExMU_writePayload;
      end
      // Beats arriving outside RD_DATA (e.g. stale ones after a reset) are dropped here.
      if (state_q == RD_DATA && i_MEM_rdValid) begin
        for (int k = 0; k < NBEATS; k++) begin
          if (beat_q == CNT_W'(k)) payload_q[k*BEAT_WIDTH +: BEAT_WIDTH] <= i_MEM_rdData;
        end
        beat_q <= beat_last ? '0 : beat_q + 1'b1;
      end
      if (state_q == WR_BEAT && i_MEM_wrReady) begin
        beat_q <= beat_last ? '0 : beat_q + 1'b1;
      end
    end
  end

  exmu_beat_serializer #(
    .BEAT_WIDTH (BEAT_WIDTH),
    .NBEATS     (NBEATS),
    .CNT_W      (CNT_W)
  ) u_serializer (
    .line      (wr_line_q),
    .beat      (beat_q),
    .beat_data (ser_data)
  );

  assign rd_active = (state_q == RD_REQ) || (state_q == RD_DATA) || (state_q == DONE_RD);
  assign wr_active = (state_q == WR_BEAT) || (state_q == DONE_WR);

  assign o_INT_readPayload = payload_q;
  assign o_INT_readDone    = (state_q == DONE_RD);
  assign o_INT_writeDone   = (state_q == DONE_WR);
  assign o_INT_busy        = (state_q != IDLE);
  assign o_status          = {29'b0, wr_active, rd_active, drop_q};

  // Memory-side outputs are forced to zero outside their owning state so the
  // port is quiet whenever that channel is not in use.
  assign o_MEM_rdReq   = (state_q == RD_REQ);
  assign o_MEM_rdAddr  = o_MEM_rdReq ? line_addr_q : '0;
  assign o_MEM_wrValid = (state_q == WR_BEAT);
  assign o_MEM_wrAddr  = o_MEM_wrValid ? (line_addr_q + ADDR_WIDTH'(beat_q) * BEAT_BYTES) : '0;
  assign o_MEM_wrData  = o_MEM_wrValid ? ser_data : '0;

endmodule

// File: tb/tb_exmu_line_mover.sv
module tb_exmu_line_mover;

  logic          clk = 1'b0;
  logic          rst;
  logic          lineRead, lineWrite;
  logic [18:0]   readID, writeID;
  logic [2047:0] writePayload;
  logic          rdReqReady, rdValid, wrReady;
  logic [255:0]  rdData;

  logic [2047:0] payload_a, payload_b;
  logic          readDone_a, readDone_b, writeDone_a, writeDone_b, busy_a, busy_b;
  logic [31:0]   status_a, status_b;
  logic          rdReq_a, rdReq_b, wrValid_a, wrValid_b;
  logic [31:0]   rdAddr_a, rdAddr_b, wrAddr_a, wrAddr_b;
  logic [255:0]  wrData_a, wrData_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  exmu_line_mover #(.BEAT_WIDTH(256), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
    .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst),
    .i_CU_lineRead(lineRead), .i_CU_lineReadID(readID),
    .o_INT_readPayload(payload_a), .o_INT_readDone(readDone_a),
    .i_CU_lineWrite(lineWrite), .i_ExMU_writeID(writeID), .i_ExMU_writePayload(writePayload),
    .o_INT_writeDone(writeDone_a), .o_INT_busy(busy_a), .o_status(status_a),
    .o_MEM_rdReq(rdReq_a), .o_MEM_rdAddr(rdAddr_a), .i_MEM_rdReqReady(rdReqReady),
    .i_MEM_rdValid(rdValid), .i_MEM_rdData(rdData),
    .o_MEM_wrValid(wrValid_a), .o_MEM_wrAddr(wrAddr_a), .o_MEM_wrData(wrData_a),
    .i_MEM_wrReady(wrReady)
  );

  exmu_line_mover #(.BEAT_WIDTH(256), .ADDR_WIDTH(32), .BASE_ADDR(32'h8000_0000)) dut_b (
    .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst),
    .i_CU_lineRead(lineRead), .i_CU_lineReadID(readID),
    .o_INT_readPayload(payload_b), .o_INT_readDone(readDone_b),
    .i_CU_lineWrite(lineWrite), .i_ExMU_writeID(writeID), .i_ExMU_writePayload(writePayload),
    .o_INT_writeDone(writeDone_b), .o_INT_busy(busy_b), .o_status(status_b),
    .o_MEM_rdReq(rdReq_b), .o_MEM_rdAddr(rdAddr_b), .i_MEM_rdReqReady(rdReqReady),
    .i_MEM_rdValid(rdValid), .i_MEM_rdData(rdData),
    .o_MEM_wrValid(wrValid_b), .o_MEM_wrAddr(wrAddr_b), .o_MEM_wrData(wrData_b),
    .i_MEM_wrReady(wrReady)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (busy_a !== 1'b0 || rdReq_a !== 1'b0 || wrValid_a !== 1'b0 ||
        readDone_a !== 1'b0 || writeDone_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy=%b rdReq=%b wrValid=%b readDone=%b writeDone=%b, expected all 0",
               busy_a, rdReq_a, wrValid_a, readDone_a, writeDone_a);
    end
    vectors++;
    if (status_a !== 32'h0 || rdAddr_a !== 32'h0 || wrAddr_a !== 32'h0 || wrData_a !== 256'h0) begin
      miscompares++;
      $display("FAIL reset_data: status=%h rdAddr=%h wrAddr=%h wrData_nz=%b, expected 0",
               status_a, rdAddr_a, wrAddr_a, |wrData_a);
    end
    vectors++;
    if (payload_a !== 2048'h0) begin
      miscompares++;
      $display("FAIL reset_payload: nonzero=%b expected 0", |payload_a);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic run_read(input logic [18:0] id, input logic [31:0] exp_addr,
                          input logic [31:0] exp_addr_b, input bit rand_data);
    logic [255:0] exp_q[$];
    logic [255:0] beat_v;
    logic [255:0] got;
    logic [255:0] want;
    lineRead = 1'b1;
    readID = id;
    rdReqReady = 1'b0;
    tick();
    lineRead = 1'b0;
    vectors++;
    if (rdReq_a !== 1'b1 || rdAddr_a !== exp_addr || status_a[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL read_req: rdReq=%b addr=%h stat1=%b, expected 1 %h 1", rdReq_a, rdAddr_a, status_a[1], exp_addr);
    end
    vectors++;
    if (rdAddr_b !== exp_addr_b) begin
      miscompares++;
      $display("FAIL read_addr_base: got %h expected %h", rdAddr_b, exp_addr_b);
    end
    tick();
    vectors++;
    if (rdReq_a !== 1'b1 || rdAddr_a !== exp_addr) begin
      miscompares++;
      $display("FAIL read_req_hold: rdReq=%b addr=%h, expected 1 %h", rdReq_a, rdAddr_a, exp_addr);
    end
    rdReqReady = 1'b1;
    tick();
    rdReqReady = 1'b0;
    vectors++;
    if (rdReq_a !== 1'b0 || busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL read_req_drop: rdReq=%b busy=%b, expected 0 1", rdReq_a, busy_a);
    end
    for (int k = 0; k < 8; k++) begin
      if (rand_data) begin
        for (int j = 0; j < 8; j++) beat_v[j*32 +: 32] = $urandom;
      end else begin
        beat_v = 256'(k);
      end
      exp_q.push_back(beat_v);
      rdValid = 1'b1;
      rdData = beat_v;
      tick();
      if (k < 7) begin
        vectors++;
        if (readDone_a !== 1'b0) begin
          miscompares++;
          $display("FAIL read_done_early: beat %0d readDone=%b expected 0", k, readDone_a);
        end
      end
    end
    rdValid = 1'b0;
    vectors++;
    if (readDone_a !== 1'b1) begin
      miscompares++;
      $display("FAIL read_done: got %b expected 1", readDone_a);
    end
    for (int k = 0; k < 8; k++) begin
      want = exp_q.pop_front();
      got = payload_a[k*256 +: 256];
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL read_payload[%0d]: got %h expected %h", k, got, want);
      end
    end
    tick();
    vectors++;
    if (readDone_a !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL read_end: readDone=%b busy=%b expected 0 0", readDone_a, busy_a);
    end
  endtask

  // read_at: -1 no read, 0 read in the same cycle as the write, n>0 read n cycles into the write
  task automatic run_write(input logic [18:0] id, input logic [31:0] exp_base,
                           input logic [2047:0] data, input int read_at);
    logic [31:0]  addr_q[$];
    logic [255:0] data_q[$];
    int done_cnt = 0;
    int rdreq_seen = 0;
    int rddone_seen = 0;
    bit prev_last_hs = 1'b0;
    bit hs_now;
    for (int k = 0; k < 8; k++) begin
      addr_q.push_back(exp_base + 32'(k * 32));
      data_q.push_back(data[k*256 +: 256]);
    end
    lineWrite = 1'b1;
    writeID = id;
    writePayload = data;
    lineRead = (read_at == 0);
    readID = id;
    wrReady = 1'b0;
    tick();
    lineWrite = 1'b0;
    lineRead = 1'b0;
    writePayload = ~data;
    vectors++;
    if (wrValid_a !== 1'b1 || status_a[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL write_start: wrValid=%b stat2=%b expected 1 1", wrValid_a, status_a[2]);
    end
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (rdReq_a) rdreq_seen++;
      if (readDone_a) rddone_seen++;
      if (writeDone_a) begin
        done_cnt++;
        vectors++;
        if (prev_last_hs !== 1'b1) begin
          miscompares++;
          $display("FAIL write_done_timing: writeDone not in cycle after last handshake (cyc %0d)", cyc);
        end
      end
      if (wrValid_a) begin
        vectors++;
        if (addr_q.size() == 0) begin
          miscompares++;
          $display("FAIL write_extra_beat: addr=%h, expected no beat", wrAddr_a);
        end else if (wrAddr_a !== addr_q[0] || wrData_a !== data_q[0]) begin
          miscompares++;
          $display("FAIL write_beat: addr=%h data=%h, expected %h %h", wrAddr_a, wrData_a, addr_q[0], data_q[0]);
        end
      end
      lineRead = (read_at > 0 && cyc == read_at);
      readID = id ^ 19'h00020;
      wrReady = (cyc % 2 == 1);
      hs_now = wrValid_a && wrReady;
      prev_last_hs = hs_now && (addr_q.size() == 1);
      tick();
      if (hs_now && addr_q.size() > 0) begin
        void'(addr_q.pop_front());
        void'(data_q.pop_front());
      end
      lineRead = 1'b0;
      if (done_cnt > 0 && !busy_a) break;
    end
    wrReady = 1'b0;
    vectors++;
    if (done_cnt != 1 || addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL write_done_count: done=%0d left=%0d, expected 1 0", done_cnt, addr_q.size());
    end
    vectors++;
    if (busy_a !== 1'b0 || wrValid_a !== 1'b0) begin
      miscompares++;
      $display("FAIL write_end: busy=%b wrValid=%b expected 0 0", busy_a, wrValid_a);
    end
    vectors++;
    if (rdreq_seen != 0 || rddone_seen != 0) begin
      miscompares++;
      $display("FAIL write_no_read: rdReq cycles=%0d readDone=%0d expected 0 0", rdreq_seen, rddone_seen);
    end
  endtask

  task automatic rand_line(output logic [2047:0] l);
    for (int j = 0; j < 64; j++) l[j*32 +: 32] = $urandom;
  endtask

  task automatic test_read_basic();
    run_read(19'h00040, 32'h0000_0200, 32'h8000_0200, 1'b0);
  endtask

  task automatic test_write_toggle();
    logic [2047:0] l;
    rand_line(l);
    run_write(19'h0003F, 32'h0000_0100, l, -1);
    vectors++;
    if (status_a !== 32'h0) begin
      miscompares++;
      $display("FAIL status_clean: got %h expected 0", status_a);
    end
  endtask

  task automatic test_collision();
    logic [2047:0] l;
    rand_line(l);
    run_write(19'h00040, 32'h0000_0200, l, 0);
    vectors++;
    if (status_a[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_sticky: got %b expected 1", status_a[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    lineRead = 1'b1;
    readID = 19'h00040;
    tick();
    lineRead = 1'b0;
    rdReqReady = 1'b1;
    tick();
    rdReqReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rdValid = 1'b1;
      rdData = {8{32'hA5A5_0000 | 32'(k)}};
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy_a !== 1'b0 || rdReq_a !== 1'b0 || readDone_a !== 1'b0 || status_a !== 32'h0 ||
        payload_a !== 2048'h0 || wrValid_a !== 1'b0 || rdAddr_a !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: busy=%b rdReq=%b done=%b status=%h payload_nz=%b, expected all 0",
               busy_a, rdReq_a, readDone_a, status_a, |payload_a);
    end
    for (int k = 0; k < 4; k++) begin
      rdData = {8{32'h5A5A_0000 | 32'(k)}};
      tick();
    end
    rdValid = 1'b0;
    vectors++;
    if (busy_a !== 1'b0 || payload_a !== 2048'h0 || readDone_a !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_stale: busy=%b payload_nz=%b done=%b, expected 0 0 0",
               busy_a, |payload_a, readDone_a);
    end
    run_read(19'h00123, 32'h0000_0900, 32'h8000_0900, 1'b1);
  endtask

  task automatic test_busy_drop();
    logic [2047:0] l;
    rand_line(l);
    run_write(19'h000C5, 32'h0000_0600, l, 2);
    vectors++;
    if (status_a[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_drop_sticky: got %b expected 1", status_a[0]);
    end
  endtask

  task automatic test_base_addr();
    run_read(19'h7FFFF, 32'h003F_FF00, 32'h803F_FF00, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    lineRead = 1'b0;
    lineWrite = 1'b0;
    readID = '0;
    writeID = '0;
    writePayload = '0;
    rdReqReady = 1'b0;
    rdValid = 1'b0;
    rdData = '0;
    wrReady = 1'b0;
    test_reset();
    test_read_basic();
    test_write_toggle();
    test_collision();
    test_reset_mid_read();
    test_busy_drop();
    test_base_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
